time_set_ctrl: RTL and testbench
================================

# time_set_ctrl

Button-driven setting controller that drives the `select_item`, `up` and `down` inputs of the BCD time/date `counter`. It debounces three raw push-buttons and steps through the editable fields with a mode state machine. Each accepted up/down press is held as a request until the counter's next 1 Hz sampling tick, so exactly one step is applied per press. It also provides a `blink` flag so the display can flash the field being edited.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles a synchronized button level must hold before it is accepted (≥2).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `tick_1hz`  in  1  one-cycle strobe in the `clk` domain marking the cycle in which `counter` samples `up`/`down`.
- `btn_mode`  in  1  raw mode button, active-high, asynchronous.
- `btn_up`  in  1  raw up button, active-high, asynchronous.
- `btn_down`  in  1  raw down button, active-high, asynchronous.
- `select_item`  out  3  field selector: 0 = ss, 1 = mm, 2 = hh, 3 = dd, 4 = mo, 5 = yyyy, 7 = run (no edit); 6 never driven.
- `up`  out  1  registered increment request for the selected field.
- `down`  out  1  registered decrement request for the selected field.
- `blink`  out  1  high during blank half-periods of the edited field; always 0 in run.

## Operation
- Each button path: 2-FF synchronizer, then debouncer, then rising-edge detector. The edge detector output is a one-cycle `press` event.
- Debouncer:
  - If the synced level equals the debounced state, counter = 0.
  - Otherwise the counter increments each cycle.
  - When the counter reaches `DEBOUNCE_CYCLES-1` while the levels still differ, the debounced state takes the synced level and the counter clears.
- Mode FSM; state encoding equals `select_item`:
  - RUN(7) → SS(0) → MM(1) → HH(2) → DD(3) → MO(4) → YYYY(5) → RUN on each mode press.
  - No other transitions.
- Request latch, with `pend_up` and `pend_dn` driving `up` and `down` directly:
  - In RUN, up and down presses are ignored.
  - In an edit state, an up press sets `pend_up` and clears `pend_dn`. A down press does the symmetric.
  - A press in the same direction as an already pending request is dropped (no accumulation).
  - Simultaneous up and down presses in the same cycle are both ignored and leave pending state unchanged.
  - A mode press clears both pending bits. A step is never applied to the newly selected field.
  - At the clock edge ending a `tick_1hz` cycle, both pending bits clear. A press detected in that same cycle wins: its bit is set for the next tick.
- Blink:
  - `blink` clears on every mode press and in RUN.
  - In an edit state it toggles on each `tick_1hz`.
- `up` and `down` are never both 1.

## Timing
- Reset values: `select_item` = 7, `up` = 0, `down` = 0, `blink` = 0. Synchronizers, debounced states, edge-detect history and counters are all 0.
- Reset assertion mid-request drops the request immediately (asynchronous). After release, a button already held high is accepted as a new press once debounced.
- Latency: a raw level held stable from before edge 1 is debounced at edge `DEBOUNCE_CYCLES+2`. The press acts at edge `DEBOUNCE_CYCLES+3`, so `up`/`down`/`select_item` change right after that edge.
- A request stays high continuously until the edge ending the next `tick_1hz` cycle. It is therefore high during exactly one tick cycle.
- A glitch shorter than `DEBOUNCE_CYCLES` synced cycles produces no press. A held button produces one press (no auto-repeat).

## Structure
- Shared package `clock_pkg`: `SEL_SS`=0, `SEL_MM`=1, `SEL_HH`=2, `SEL_DD`=3, `SEL_MO`=4, `SEL_YYYY`=5, `SEL_RUN`=7, as 3-bit constants. `counter` and the display path use the same constants.
- Sub-module `btn_debounce` (synchronizer + debouncer + edge detect, parameter `DEBOUNCE_CYCLES`, outputs `level`, `press`), instantiated three times.
- Top contains the mode FSM, request latch and blink register.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4` and `tick_1hz` every 16 cycles.
- Reset held 3 cycles, then released → `select_item`=7, `up`=`down`=`blink`=0. Reasserting `rst` mid-run returns the same values asynchronously.
- 7 clean mode presses (10 cycles high, 10 cycles low each) → `select_item` sequence 0,1,2,3,4,5,7. `blink` toggles only in states 0–5 and is 0 after each mode press.
- In SS, `btn_up` high for 10 cycles starting at cycle 0 → `up` rises after edge 7 and falls at the edge ending the next tick. Exactly one tick cycle sees `up`=1.
- `btn_up` bouncing with 3-cycle-high/3-cycle-low pulses for 40 cycles → `up` stays 0.
- In MM, up press then down press before the tick → `up` falls as `down` rises, never both 1, and the tick sees `down`=1 only. An up press in RUN leaves `up`=0.
- Up pending in HH, mode press before the tick → `select_item`=3 and `up`=0 at the tick. A press landing in the tick cycle → `up` is high for the following tick.

Source files
------------

// File: rtl/clock_pkg.sv
// Field-selector encoding shared by the setting controller, the BCD counter and the display path.
package clock_pkg;

  localparam logic [2:0] SEL_SS   = 3'd0;
  localparam logic [2:0] SEL_MM   = 3'd1;
  localparam logic [2:0] SEL_HH   = 3'd2;
  localparam logic [2:0] SEL_DD   = 3'd3;
  localparam logic [2:0] SEL_MO   = 3'd4;
  localparam logic [2:0] SEL_YYYY = 3'd5;
  localparam logic [2:0] SEL_RUN  = 3'd7;

  typedef enum logic [2:0] {
    FLD_SS   = SEL_SS,
    FLD_MM   = SEL_MM,
    FLD_HH   = SEL_HH,
    FLD_DD   = SEL_DD,
    FLD_MO   = SEL_MO,
    FLD_YYYY = SEL_YYYY,
    FLD_RUN  = SEL_RUN
  } field_e;

  // Order in which the mode button walks the editable fields.
  function automatic field_e next_field(input field_e f);
    case (f)
      FLD_RUN:  return FLD_SS;
      FLD_SS:   return FLD_MM;
      FLD_MM:   return FLD_HH;
      FLD_HH:   return FLD_DD;
      FLD_DD:   return FLD_MO;
      FLD_MO:   return FLD_YYYY;
      FLD_YYYY: return FLD_RUN;
      default:  return FLD_RUN;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button path: 2-FF synchronizer, stable-count debouncer and rising-edge press strobe.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      prev  <= level;
      // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles in a row.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~prev;

endmodule

// File: rtl/time_set_ctrl.sv
// Setting controller: mode FSM over the editable fields, one-step up/down request latch, blink flag.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] select_item,
  output logic       up,
  output logic       down,
  output logic       blink
);

  field_e state, state_n;
  logic   pend_up, pend_up_n;
  logic   pend_dn, pend_dn_n;
  logic   blink_n;
  logic   lvl_mode, lvl_up, lvl_dn;
  logic   press_mode, press_up, press_dn;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .rst(rst), .raw(btn_mode), .level(lvl_mode), .press(press_mode)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk(clk), .rst(rst), .raw(btn_up), .level(lvl_up), .press(press_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk(clk), .rst(rst), .raw(btn_down), .level(lvl_dn), .press(press_dn)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= FLD_RUN;
      pend_up <= 1'b0;
      pend_dn <= 1'b0;
      blink   <= 1'b0;
    end else begin
      state   <= state_n;
      pend_up <= pend_up_n;
      pend_dn <= pend_dn_n;
      blink   <= blink_n;
    end
  end

  // A press seen in a tick cycle overrides the tick clear, so it is held for the following tick.
  always_comb begin
    state_n   = state;
    pend_up_n = pend_up;
    pend_dn_n = pend_dn;
    blink_n   = blink;
    if (press_mode) begin
      state_n   = next_field(state);
      pend_up_n = 1'b0;
      pend_dn_n = 1'b0;
      blink_n   = 1'b0;
    end else if (state == FLD_RUN) begin
      pend_up_n = 1'b0;
      pend_dn_n = 1'b0;
      blink_n   = 1'b0;
    end else begin
      if (tick_1hz) begin
        pend_up_n = 1'b0;
        pend_dn_n = 1'b0;
        blink_n   = ~blink;
      end
      if (press_up && !press_dn) begin
        pend_up_n = 1'b1;
        pend_dn_n = 1'b0;
      end else if (press_dn && !press_up) begin
        pend_up_n = 1'b0;
        pend_dn_n = 1'b1;
      end
    end
  end

  assign select_item = state;
  assign up          = pend_up;
  assign down        = pend_dn;

  a_press_mode : assert property (@(posedge clk) disable iff (rst) press_mode |-> lvl_mode);
  a_press_up   : assert property (@(posedge clk) disable iff (rst) press_up |-> lvl_up);
  a_press_dn   : assert property (@(posedge clk) disable iff (rst) press_dn |-> lvl_dn);
  a_exclusive  : assert property (@(posedge clk) disable iff (rst) !(pend_up && pend_dn));

endmodule

// File: tb/tb_time_set_ctrl.sv
// Bench for time_set_ctrl: behavioural reference model checked every cycle, a press table and corner sequences.
module tb_time_set_ctrl;

  localparam int unsigned D      = 4;
  localparam int          TICK_P = 16;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_up   = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] select_item;
  logic       up, down, blink;

  time_set_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
    .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
    .select_item(select_item), .up(up), .down(down), .blink(blink)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit tick_auto = 1'b0;
  int tick_cnt  = 0;
  bit model_chk = 1'b0;

  task automatic check(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: field list walked by index, debounce as "last D synced samples all differ".
  int fld[7] = '{0, 1, 2, 3, 4, 5, 7};
  bit sh0[$], sh1[$], sh2[$];
  bit rh[3][2];
  bit m_deb[3], m_prev[3];
  int m_idx = 6;
  bit m_up = 1'b0, m_dn = 1'b0, m_blink = 1'b0;

  function automatic bit window_flips(input bit q[$], input bit deb);
    if (q.size() < D) return 1'b0;
    for (int i = 0; i < D; i++) if (q[i] == deb) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or posedge rst) begin
    bit raw[3];
    bit pr[3];
    bit syn[3];
    if (rst) begin
      sh0.delete(); sh1.delete(); sh2.delete();
      for (int b = 0; b < 3; b++) begin
        rh[b][0] = 1'b0; rh[b][1] = 1'b0;
        m_deb[b] = 1'b0; m_prev[b] = 1'b0;
      end
      m_idx = 6; m_up = 1'b0; m_dn = 1'b0; m_blink = 1'b0;
    end else begin
      raw[0] = btn_mode; raw[1] = btn_up; raw[2] = btn_down;
      for (int b = 0; b < 3; b++) begin
        pr[b]     = m_deb[b] && !m_prev[b];
        m_prev[b] = m_deb[b];
        syn[b]    = rh[b][1];          // raw level two edges ago
        rh[b][1]  = rh[b][0];
        rh[b][0]  = raw[b];
      end
      sh0.push_front(syn[0]); if (sh0.size() > D) void'(sh0.pop_back());
      sh1.push_front(syn[1]); if (sh1.size() > D) void'(sh1.pop_back());
      sh2.push_front(syn[2]); if (sh2.size() > D) void'(sh2.pop_back());
      if (window_flips(sh0, m_deb[0])) m_deb[0] = !m_deb[0];
      if (window_flips(sh1, m_deb[1])) m_deb[1] = !m_deb[1];
      if (window_flips(sh2, m_deb[2])) m_deb[2] = !m_deb[2];

      if (pr[0]) begin
        m_idx = (m_idx + 1) % 7;
        m_up = 1'b0; m_dn = 1'b0; m_blink = 1'b0;
      end else if (m_idx != 6) begin
        if (tick_1hz) begin
          m_up = 1'b0; m_dn = 1'b0; m_blink = !m_blink;
        end
        if (pr[1] && !pr[2]) begin m_up = 1'b1; m_dn = 1'b0; end
        else if (pr[2] && !pr[1]) begin m_dn = 1'b1; m_up = 1'b0; end
      end
    end
  end

  always @(negedge clk) begin
    if (model_chk && !rst) begin
      check("model_sel",   int'(select_item), fld[m_idx]);
      check("model_up",    int'(up),          int'(m_up));
      check("model_down",  int'(down),        int'(m_dn));
      check("model_blink", int'(blink),       int'(m_blink));
      check("up_down_excl", int'(up & down),  0);
    end
  end

  task automatic step(input bit mt = 1'b0);
    @(negedge clk);
    if (tick_auto) begin
      tick_1hz = (tick_cnt == TICK_P - 1);
      tick_cnt = (tick_cnt + 1) % TICK_P;
    end else begin
      tick_1hz = mt;
    end
  endtask

  task automatic press(input bit m, input bit u, input bit d);
    step();
    btn_mode = m; btn_up = u; btn_down = d;
    repeat (10) step();
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (10) step();
  endtask

  task automatic tick_pulse();
    step(1'b1);
    step();
  endtask

  typedef struct {
    bit m; bit u; bit d;
    int sel; bit eu; bit ed;
  } vec_t;

  vec_t tbl[15];

  initial begin
    int cnt_hi;
    tbl[0]  = '{0, 1, 0, 7, 0, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 0, 1, 0};
    tbl[4]  = '{0, 0, 1, 0, 0, 1};
    tbl[5]  = '{0, 1, 1, 0, 0, 1};
    tbl[6]  = '{1, 0, 0, 1, 0, 0};
    tbl[7]  = '{0, 0, 1, 1, 0, 1};
    tbl[8]  = '{1, 0, 0, 2, 0, 0};
    tbl[9]  = '{1, 0, 0, 3, 0, 0};
    tbl[10] = '{1, 0, 0, 4, 0, 0};
    tbl[11] = '{1, 0, 0, 5, 0, 0};
    tbl[12] = '{0, 1, 0, 5, 1, 0};
    tbl[13] = '{1, 0, 0, 7, 0, 0};
    tbl[14] = '{0, 0, 1, 7, 0, 0};

    // Reset held three cycles
    repeat (3) step();
    rst = 1'b0;
    model_chk = 1'b1;
    step();
    check("rst_sel",   int'(select_item), 7);
    check("rst_up",    int'(up),    0);
    check("rst_down",  int'(down),  0);
    check("rst_blink", int'(blink), 0);

    // Press table, no ticks
    foreach (tbl[i]) begin
      press(tbl[i].m, tbl[i].u, tbl[i].d);
      check($sformatf("tbl%0d_sel", i),  int'(select_item), tbl[i].sel);
      check($sformatf("tbl%0d_up", i),   int'(up),          int'(tbl[i].eu));
      check($sformatf("tbl%0d_down", i), int'(down),        int'(tbl[i].ed));
      check($sformatf("tbl%0d_blink", i), int'(blink),      0);
    end

    // Blink in SS, cleared by mode press
    press(1, 0, 0);
    check("ss_sel", int'(select_item), 0);
    tick_pulse(); check("blink_1", int'(blink), 1);
    tick_pulse(); check("blink_2", int'(blink), 0);
    tick_pulse(); check("blink_3", int'(blink), 1);
    press(1, 0, 0);
    check("mm_sel", int'(select_item), 1);
    check("mm_blink_clr", int'(blink), 0);

    // One up step seen by exactly one tick
    press(0, 1, 0);
    check("mm_up_pend", int'(up), 1);
    step(1'b1);
    check("tick_sees_up", int'(up), 1);
    step();
    check("up_cleared", int'(up), 0);

    // Up then down before the tick
    press(0, 1, 0);
    press(0, 0, 1);
    check("swap_up", int'(up), 0);
    check("swap_down", int'(down), 1);
    step(1'b1);
    check("tick_sees_down", int'(down), 1);
    check("tick_no_up", int'(up), 0);
    step();
    check("down_cleared", int'(down), 0);

    // Pending up dropped by a mode press
    press(1, 0, 0);
    check("hh_sel", int'(select_item), 2);
    press(0, 1, 0);
    check("hh_up", int'(up), 1);
    press(1, 0, 0);
    check("dd_sel", int'(select_item), 3);
    check("mode_drops_up", int'(up), 0);
    tick_pulse();
    check("tick_after_mode", int'(up), 0);

    // Press landing in the tick cycle survives into the next tick period
    press(0, 1, 0);
    step();
    btn_up = 1'b1;
    repeat (5) step();
    step(1'b1);
    check("old_up_in_tick", int'(up), 1);
    step();
    check("new_up_wins", int'(up), 1);
    repeat (6) step();
    btn_up = 1'b0;
    repeat (10) step();
    check("held_for_next", int'(up), 1);
    step(1'b1);
    check("next_tick_up", int'(up), 1);
    step();
    check("next_tick_clr", int'(up), 0);

    // Bounce shorter than the debounce window
    cnt_hi = 0;
    for (int k = 0; k < 7; k++) begin
      step(); btn_up = 1'b1; if (up) cnt_hi++;
      repeat (2) begin step(); if (up) cnt_hi++; end
      step(); btn_up = 1'b0; if (up) cnt_hi++;
      repeat (2) begin step(); if (up) cnt_hi++; end
    end
    repeat (10) begin step(); if (up) cnt_hi++; end
    check("bounce_no_up", cnt_hi, 0);

    // Asynchronous reset drops a request; held button accepted after release
    press(0, 1, 0);
    check("pre_rst_up", int'(up), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_sel",   int'(select_item), 7);
    check("arst_up",    int'(up),    0);
    check("arst_blink", int'(blink), 0);
    btn_mode = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (12) step();
    check("held_mode_press", int'(select_item), 0);
    btn_mode = 1'b0;
    repeat (10) step();

    // Random buttons with free-running tick
    tick_auto = 1'b1;
    tick_cnt  = 0;
    for (int s = 0; s < 220; s++) begin
      int r;
      r = int'($urandom_range(0, 9));
      btn_mode = (r == 0) || (r == 6);
      btn_up   = (r == 1) || (r == 2) || (r == 5);
      btn_down = (r == 3) || (r == 4) || (r == 5);
      repeat ($urandom_range(1, 14)) step();
    end
    btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    repeat (40) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
